// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave receiver.
//   spi_state_e    : receiver FSM states (IDLE while chip select is high,
//                    SHIFT while it is low)
//   SPI_WORD_W     : default word width in bits
//   SPI_CNT_W      : width of the bit counter output
//   SPI_IN_STAGES  : clk edges between a pin change and the edge-detect input
//                    register (3 with SPI_RX_SYNC_EN, 1 otherwise)
// Configuration macro: SPI_RX_SYNC_EN
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int unsigned SPI_WORD_W = 16;
  localparam int unsigned SPI_CNT_W  = 5;

`ifdef SPI_RX_SYNC_EN
  localparam int unsigned SPI_IN_STAGES = 3;
`else
  localparam int unsigned SPI_IN_STAGES = 1;
`endif

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Next value of a saturating pipeline-fill counter.
  function automatic logic [1:0] prime_next(input logic [1:0] cnt);
    if (cnt == 2'(SPI_IN_STAGES)) begin
      prime_next = cnt;
    end else begin
      prime_next = cnt + 2'd1;
    end
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings the SPI pins into the clk domain and detects sclk / cs rising edges.
// With SPI_RX_SYNC_EN a two-flop synchronizer precedes the input register
// (asynchronous master); without it the pins are registered once (master on
// the same clk).
// Ports:
//   clk, reset_n        : system clock, async active-low reset
//   spi_cs_l, spi_sclk,
//   spi_data            : raw SPI pins
//   cs_l_s              : registered chip select (active low)
//   data_s              : registered MOSI, aligned with sclk_rise
//   sclk_rise           : one-cycle strobe on an sclk rising edge
//   cs_rise             : one-cycle strobe on a chip-select rising edge
// Configuration macro: SPI_RX_SYNC_EN
// -----------------------------------------------------------------------------
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs_l,
  input  logic spi_sclk,
  input  logic spi_data,
  output logic cs_l_s,
  output logic data_s,
  output logic sclk_rise,
  output logic cs_rise
);

  logic cs_in_s;
  logic sclk_in_s;
  logic data_in_s;

`ifdef SPI_RX_SYNC_EN
  logic [1:0] cs_meta_r;
  logic [1:0] sclk_meta_r;
  logic [1:0] data_meta_r;

  // Two-flop synchronizers; cs idles high so its chain resets to ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta_r   <= 2'b11;
      sclk_meta_r <= 2'b00;
      data_meta_r <= 2'b00;
    end else begin
      cs_meta_r   <= {cs_meta_r[0], spi_cs_l};
      sclk_meta_r <= {sclk_meta_r[0], spi_sclk};
      data_meta_r <= {data_meta_r[0], spi_data};
    end
  end

  assign cs_in_s   = cs_meta_r[1];
  assign sclk_in_s = sclk_meta_r[1];
  assign data_in_s = data_meta_r[1];
`else
  assign cs_in_s   = spi_cs_l;
  assign sclk_in_s = spi_sclk;
  assign data_in_s = spi_data;
`endif

  logic cs_r;
  logic sclk_r;
  logic data_r;
  logic cs_hist_r;
  logic sclk_hist_r;

  // Input register plus one-cycle history used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_r        <= 1'b1;
      sclk_r      <= 1'b0;
      data_r      <= 1'b0;
      cs_hist_r   <= 1'b1;
      sclk_hist_r <= 1'b0;
    end else begin
      cs_r        <= cs_in_s;
      sclk_r      <= sclk_in_s;
      data_r      <= data_in_s;
      cs_hist_r   <= cs_r;
      sclk_hist_r <= sclk_r;
    end
  end

  assign cs_l_s    = cs_r;
  assign data_s    = data_r;
  assign sclk_rise = sclk_r & ~sclk_hist_r;
  assign cs_rise   = cs_r & ~cs_hist_r;

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 style slave receiver: MSB-first words of WIDTH bits are shifted
// in on sclk rising edges while spi_cs_l is low and handed to a consumer with
// a valid/ready handshake. Back-to-back words under one chip select are
// supported.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   spi_cs_l     : chip select, active low
//   spi_sclk     : serial clock, data sampled on its rising edge
//   spi_data     : serial data (MOSI)
//   rx_data      : last completed word
//   rx_valid     : rx_data holds an unconsumed word
//   rx_ready     : consumer takes rx_data when rx_valid && rx_ready
//   overrun      : one-cycle pulse when a completed word is dropped
//   frame_err    : one-cycle pulse when chip select rises mid-word
//   bit_cnt      : bits received in the current word
// Configuration macro: SPI_RX_SYNC_EN (two-flop synchronizers on the pins)
// -----------------------------------------------------------------------------
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WORD_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_cs_l,
  input  logic                 spi_sclk,
  input  logic                 spi_data,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [SPI_CNT_W-1:0] bit_cnt
);

  localparam logic [SPI_CNT_W-1:0] CNT_LAST = SPI_CNT_W'(WIDTH - 1);
  localparam logic [SPI_CNT_W-1:0] CNT_ONE  = SPI_CNT_W'(1);

  logic cs_l_s;
  logic data_s;
  logic sclk_rise;
  logic cs_rise;

  spi_sync_edge u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs_l  (spi_cs_l),
    .spi_sclk  (spi_sclk),
    .spi_data  (spi_data),
    .cs_l_s    (cs_l_s),
    .data_s    (data_s),
    .sclk_rise (sclk_rise),
    .cs_rise   (cs_rise)
  );

  spi_state_e           state_r;
  spi_state_e           state_nx;
  logic [WIDTH-1:0]     shift_r;
  logic [WIDTH-1:0]     shift_nx;
  logic [SPI_CNT_W-1:0] bit_cnt_r;
  logic [SPI_CNT_W-1:0] bit_cnt_nx;
  logic [WIDTH-1:0]     rx_data_r;
  logic [WIDTH-1:0]     rx_data_nx;
  logic                 rx_valid_r;
  logic                 rx_valid_nx;
  logic                 overrun_r;
  logic                 overrun_nx;
  logic                 frame_err_r;
  logic                 frame_err_nx;
  logic                 armed_r;
  logic                 armed_nx;
  logic [1:0]           prime_r;
  logic [1:0]           prime_nx;
  logic                 word_done_s;
  logic [WIDTH-1:0]     word_s;

  // The completed word includes the bit arriving in this cycle.
  assign word_s = {shift_r[WIDTH-2:0], data_s};

  // Arming: the reset value sitting in the input pipeline is not a real
  // observation of cs high, so wait until the pipeline has filled with pin
  // samples and then require cs high before any transfer may start.
  always_comb begin
    prime_nx = prime_next(prime_r);
    armed_nx = armed_r;
    if (!armed_r && (prime_r == 2'(SPI_IN_STAGES)) && cs_l_s) begin
      armed_nx = 1'b1;
    end else begin
      armed_nx = armed_r;
    end
  end

  // Receiver FSM next state, shift register and bit counter.
  always_comb begin
    state_nx     = state_r;
    shift_nx     = shift_r;
    bit_cnt_nx   = bit_cnt_r;
    frame_err_nx = 1'b0;
    word_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (armed_r && !cs_l_s) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
        end else begin
          state_nx   = IDLE;
        end
      end
      SHIFT: begin
        // A cs rise wins over a simultaneous sclk rise.
        if (cs_l_s) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          if (cs_rise && (bit_cnt_r != '0)) begin
            frame_err_nx = 1'b1;
            shift_nx     = '0;
          end else begin
            frame_err_nx = 1'b0;
          end
        end else if (sclk_rise) begin
          shift_nx = word_s;
          if (bit_cnt_r == CNT_LAST) begin
            bit_cnt_nx  = '0;
            word_done_s = 1'b1;
          end else begin
            bit_cnt_nx  = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_nx = SHIFT;
        end
      end
      default: begin
        state_nx   = IDLE;
        bit_cnt_nx = '0;
      end
    endcase
  end

  // Output handshake: load a finished word when the holding register is free
  // or being emptied this cycle, otherwise drop it and flag overrun.
  always_comb begin
    rx_data_nx  = rx_data_r;
    rx_valid_nx = rx_valid_r;
    overrun_nx  = 1'b0;
    if (word_done_s) begin
      if (!rx_valid_r || rx_ready) begin
        rx_data_nx  = word_s;
        rx_valid_nx = 1'b1;
      end else begin
        overrun_nx  = 1'b1;
      end
    end else if (rx_valid_r && rx_ready) begin
      rx_valid_nx = 1'b0;
    end else begin
      rx_valid_nx = rx_valid_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      armed_r     <= 1'b0;
      prime_r     <= 2'd0;
    end else begin
      state_r     <= state_nx;
      shift_r     <= shift_nx;
      bit_cnt_r   <= bit_cnt_nx;
      rx_data_r   <= rx_data_nx;
      rx_valid_r  <= rx_valid_nx;
      overrun_r   <= overrun_nx;
      frame_err_r <= frame_err_nx;
      armed_r     <= armed_nx;
      prime_r     <= prime_nx;
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign overrun   = overrun_r;
  assign frame_err = frame_err_r;
  assign bit_cnt   = bit_cnt_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
// Directed bench for spi_slave_rx acting as a same-clk MSB-first SPI master.
// Build with or without SPI_RX_SYNC_EN; the expected rx_valid latency follows.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

`ifdef SPI_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_cs_l;
  logic        spi_sclk;
  logic        spi_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        overrun;
  logic        frame_err;
  logic [4:0]  bit_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ovr_cnt  = 0;
  int          ferr_cnt = 0;
  int          ferr_save;
  logic [15:0] hs_q[$];

  spi_slave_rx #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs_l  (spi_cs_l),
    .spi_sclk  (spi_sclk),
    .spi_data  (spi_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard of handshakes and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) hs_q.push_back(rx_data);
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clk edges, leaving time just after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the first n bits of w, MSB first; sclk is left high.
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_data = w[15-i];
      spi_sclk = 1'b0;
      tick(HALF);
      spi_sclk = 1'b1;
      tick(HALF);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    spi_cs_l = 1'b1;
    spi_sclk = 1'b0;
    spi_data = 1'b0;
    rx_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_rx_data",  32'(rx_data),  32'h0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("rst_overrun",  32'(overrun),  32'h0);
    check_eq("rst_frame_err",32'(frame_err),32'h0);
    check_eq("rst_bit_cnt",  32'(bit_cnt),  32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(6);

    // Single word A569 with rx_valid latency check on the last bit
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'hA569, 15);
    check_eq("t1_bit_cnt15", 32'(bit_cnt), 32'd15);
    spi_data = 1'b1;
    spi_sclk = 1'b0;
    tick(HALF);
    spi_sclk = 1'b1;
    @(posedge clk);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check_eq("t1_lat_early", 32'(rx_valid), 32'h0);
    end
    @(negedge clk);
    check_eq("t1_lat_valid", 32'(rx_valid), 32'h1);
    tick(HALF);
    spi_cs_l = 1'b1;
    tick(8);
    check_eq("t1_hs_count", 32'(hs_q.size()), 32'd1);
    if (hs_q.size() > 0) check_eq("t1_data", 32'(hs_q[0]), 32'hA569);
    check_eq("t1_overrun", 32'(ovr_cnt), 32'd0);
    check_eq("t1_frame_err", 32'(ferr_cnt), 32'd0);
    check_eq("t1_bit_cnt", 32'(bit_cnt), 32'd0);

    // Back-to-back words
    hs_q.delete();
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'h2563, 16);
    send_bits(16'h9B63, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(8);
    check_eq("t2_hs_count", 32'(hs_q.size()), 32'd2);
    if (hs_q.size() > 1) begin
      check_eq("t2_data0", 32'(hs_q[0]), 32'h2563);
      check_eq("t2_data1", 32'(hs_q[1]), 32'h9B63);
    end
    check_eq("t2_overrun", 32'(ovr_cnt), 32'd0);

    // Overrun with consumer stalled
    hs_q.delete();
    rx_ready = 1'b0;
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'h6A61, 16);
    send_bits(16'hA265, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(4);
    @(negedge clk);
    check_eq("t3_valid_held", 32'(rx_valid), 32'h1);
    check_eq("t3_data_kept", 32'(rx_data), 32'h6A61);
    check_eq("t3_overrun", 32'(ovr_cnt), 32'd1);
    check_eq("t3_no_hs", 32'(hs_q.size()), 32'd0);
    tick(1);
    rx_ready = 1'b1;
    tick(3);
    check_eq("t3_drain_hs", 32'(hs_q.size()), 32'd1);
    if (hs_q.size() > 0) check_eq("t3_drain_data", 32'(hs_q[0]), 32'h6A61);
    check_eq("t3_valid_clear", 32'(rx_valid), 32'h0);

    // Chip select raised mid-word
    hs_q.delete();
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'h7564, 7);
    check_eq("t4_bit_cnt7", 32'(bit_cnt), 32'd7);
    spi_cs_l = 1'b1;
    tick(6);
    check_eq("t4_frame_err", 32'(ferr_cnt), 32'd1);
    check_eq("t4_bit_cnt0", 32'(bit_cnt), 32'd0);
    check_eq("t4_valid", 32'(rx_valid), 32'h0);
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'hA569, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(8);
    check_eq("t4_hs_count", 32'(hs_q.size()), 32'd1);
    if (hs_q.size() > 0) check_eq("t4_data", 32'(hs_q[0]), 32'hA569);
    check_eq("t4_no_new_ferr", 32'(ferr_cnt), 32'd1);

    // Reset mid-word
    hs_q.delete();
    ferr_save = ferr_cnt;
    rx_ready  = 1'b0;
    spi_cs_l  = 1'b0;
    tick(4);
    send_bits(16'hC3A5, 16);
    send_bits(16'h7564, 9);
    check_eq("t5_bit_cnt9", 32'(bit_cnt), 32'd9);
    check_eq("t5_valid_pre", 32'(rx_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5_async_rx_data",  32'(rx_data),  32'h0);
    check_eq("t5_async_rx_valid", 32'(rx_valid), 32'h0);
    check_eq("t5_async_overrun",  32'(overrun),  32'h0);
    check_eq("t5_async_frame_err",32'(frame_err),32'h0);
    check_eq("t5_async_bit_cnt",  32'(bit_cnt),  32'h0);
    tick(3);
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    tick(2);
    send_bits(16'hFFFF, 4);
    check_eq("t5_unarmed_bit_cnt", 32'(bit_cnt), 32'd0);
    spi_cs_l = 1'b1;
    tick(6);
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(16'h2563, 16);
    tick(8);
    spi_cs_l = 1'b1;
    tick(6);
    check_eq("t5_hs_count", 32'(hs_q.size()), 32'd1);
    if (hs_q.size() > 0) check_eq("t5_data", 32'(hs_q[0]), 32'h2563);
    check_eq("t5_no_ferr", 32'(ferr_cnt), 32'(ferr_save));

    // sclk activity with chip select high is ignored
    hs_q.delete();
    send_bits(16'hFFFF, 16);
    tick(6);
    check_eq("t6_no_hs", 32'(hs_q.size()), 32'd0);
    check_eq("t6_valid", 32'(rx_valid), 32'h0);
    check_eq("t6_bit_cnt", 32'(bit_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
